if_fetch_unit: RTL and testbench

//  Sequential instruction-fetch stage. It owns the PC register and issues one instruction-memory request at a time.

---
 rtl/if_fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit -- sequential instruction-fetch stage.
//
// Owns the PC, keeps at most one instruction-memory request in flight and
// hands {instruction, PC, next PC} to decode through a single-entry
// valid/ready output register. A redirect from EX/MEM replaces the PC and
// flushes the output register; a response already in flight is dropped.
//
// Optional build macro: IF_PERF_CNT_EN
//   defined   -> fetch_cnt / stall_cnt performance counters are built
//   undefined -> fetch_cnt / stall_cnt are tied to 0
//
// Ports
//   clk, rst_n      clock (rising edge), async active-low reset
//   redirect        take redirect_pc as next PC and flush
//   redirect_pc     branch/jump target
//   imem_req        request pulse, memory accepts imem_addr this cycle
//   imem_addr       fetch address (always equal to PC)
//   imem_rvalid     read data valid
//   imem_rdata      instruction word
//   if_valid        output register holds an instruction
//   if_ins          fetched instruction (NOP_INS when empty)
//   if_pc           address of if_ins
//   if_next_pc      if_pc + PC_STEP
//   id_ready        decode consumes if_* this cycle when if_valid=1
//   fetch_cnt       delivered-instruction count
//   stall_cnt       fetch stall-cycle count
//
// state  | meaning
// -------+-------------------------------------------------------------
// ISSUE  | slot free or being consumed: request the PC unless redirecting
// WAIT   | request outstanding, response will be delivered
// DROP   | request outstanding, response is stale and will be discarded

module if_fetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 PC_STEP  = 4,
  parameter logic [DATA_W-1:0]  NOP_INS  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_ins,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_next_pc,
  input  logic              id_ready,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] pc_seq;
  logic              req_int;
  logic              load;
  logic              consume;

  assign pc_seq    = pc + STEP;
  assign imem_addr = pc;
  // Request is combinational from state; hold it low while reset is asserted.
  assign imem_req  = req_int & rst_n;
  assign consume   = if_valid & id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_ISSUE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_int   = 1'b0;
    load      = 1'b0;
    case (state)
      S_ISSUE: begin
        // Issue only when the output slot is free or drains this cycle.
        if (!redirect && !(if_valid && !id_ready)) begin
          req_int   = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          state_nxt = imem_rvalid ? S_ISSUE : S_DROP;
        end else if (imem_rvalid) begin
          load      = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_DROP: begin
        if (!redirect && imem_rvalid) begin
          state_nxt = S_ISSUE;
        end
      end
      default: state_nxt = S_ISSUE;
    endcase
  end

  always_comb begin
    pc_nxt = pc;
    if (redirect) begin
      pc_nxt = redirect_pc;
    end else if (load) begin
      pc_nxt = pc_seq;
    end
  end

  // Output register. The slot is always free when load fires because
  // issue is gated on a free (or draining) slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid   <= 1'b0;
      if_ins     <= NOP_INS;
      if_pc      <= '0;
      if_next_pc <= '0;
    end else if (redirect) begin
      if_valid <= 1'b0;
      if_ins   <= NOP_INS;
    end else if (load) begin
      if_valid   <= 1'b1;
      if_ins     <= imem_rdata;
      if_pc      <= pc;
      if_next_pc <= pc_seq;
    end else if (consume) begin
      if_valid <= 1'b0;
      if_ins   <= NOP_INS;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic stall_cyc;

  assign stall_cyc = (state == S_ISSUE) ? !req_int : !imem_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (consume && !redirect) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (stall_cyc) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

`ifdef IF_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_ins;
  logic [31:0] if_pc;
  logic [31:0] if_next_pc;
  logic        id_ready = 1'b1;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  logic        rst8_n = 1'b0;
  logic        redirect8 = 1'b0;
  logic [7:0]  redirect_pc8 = '0;
  logic        req8;
  logic [7:0]  addr8;
  logic        rvalid8 = 1'b0;
  logic [31:0] rdata8 = '0;
  logic        valid8;
  logic [31:0] ins8;
  logic [7:0]  pc8;
  logic [7:0]  npc8;
  logic        id_ready8 = 1'b1;
  logic [31:0] fc8;
  logic [31:0] sc8;

  int lat = 1;
  int n_chk = 0;
  int n_err = 0;

  if_fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ins(if_ins), .if_pc(if_pc),
    .if_next_pc(if_next_pc), .id_ready(id_ready), .fetch_cnt(fetch_cnt),
    .stall_cnt(stall_cnt)
  );

  if_fetch_unit #(.ADDR_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .redirect(redirect8), .redirect_pc(redirect_pc8),
    .imem_req(req8), .imem_addr(addr8), .imem_rvalid(rvalid8),
    .imem_rdata(rdata8), .if_valid(valid8), .if_ins(ins8), .if_pc(pc8),
    .if_next_pc(npc8), .id_ready(id_ready8), .fetch_cnt(fc8),
    .stall_cnt(sc8)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  // Instruction memory for the 32-bit instance: latency 'lat' cycles.
  initial begin : mem32
    int cnt;
    logic [31:0] a;
    cnt = 0;
    a = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0;
        imem_rvalid = 1'b0;
      end else begin
        imem_rvalid = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata = mem_word(a);
          end
        end
        if (imem_req) begin
          a = imem_addr;
          cnt = lat;
        end
      end
    end
  end

  // Instruction memory for the 8-bit instance: fixed 1-cycle latency.
  initial begin : mem8
    int cnt;
    logic [7:0] a;
    cnt = 0;
    a = '0;
    forever begin
      @(negedge clk);
      if (!rst8_n) begin
        cnt = 0;
        rvalid8 = 1'b0;
      end else begin
        rvalid8 = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            rvalid8 = 1'b1;
            rdata8 = 32'hA5A5_0000 | {24'h0, a};
          end
        end
        if (req8) begin
          a = addr8;
          cnt = 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b1;
    lat = 1;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    // reset values while reset is held
    cyc();
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_ins", if_ins, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_npc", if_next_pc, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_fc", fetch_cnt, 32'd0);
    chk("rst_sc", stall_cnt, 32'd0);

    // 1: 1-cycle memory, decode always ready
    do_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t1_req", {31'd0, imem_req}, 32'd1);
      chk("t1_addr", imem_addr, 32'(4 * i));
      cyc(); #1;
      chk("t1_gap_valid", {31'd0, if_valid}, 32'd0);
      chk("t1_gap_req", {31'd0, imem_req}, 32'd0);
      cyc(); #1;
      chk("t1_valid", {31'd0, if_valid}, 32'd1);
      chk("t1_ins", if_ins, 32'(32'h11 * (i + 1)));
      chk("t1_pc", if_pc, 32'(4 * i));
      chk("t1_npc", if_next_pc, 32'(4 * i + 4));
    end
    chk("t1_fc", fetch_cnt, PERF ? 32'd2 : 32'd0);
    chk("t1_sc", stall_cnt, 32'd0);

    // 2: latency 3, decode stalled after the first instruction
    do_reset();
    lat = 3;
    id_ready = 1'b0;
    #1;
    chk("t2_req0", {31'd0, imem_req}, 32'd1);
    chk("t2_addr0", imem_addr, 32'd0);
    cyc(); #1;
    chk("t2_wait_req", {31'd0, imem_req}, 32'd0);
    cyc(); cyc(); #1;
    chk("t2_wait_valid", {31'd0, if_valid}, 32'd0);
    cyc(); #1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_hold_valid", {31'd0, if_valid}, 32'd1);
      chk("t2_hold_ins", if_ins, 32'h11);
      chk("t2_hold_req", {31'd0, imem_req}, 32'd0);
      chk("t2_hold_addr", imem_addr, 32'd4);
      cyc(); #1;
    end
    id_ready = 1'b1;
    #1;
    chk("t2_rel_req", {31'd0, imem_req}, 32'd1);
    chk("t2_rel_addr", imem_addr, 32'd4);
    chk("t2_sc", stall_cnt, PERF ? 32'd6 : 32'd0);
    chk("t2_fc0", fetch_cnt, 32'd0);
    cyc(); #1;
    chk("t2_drained", {31'd0, if_valid}, 32'd0);
    chk("t2_nop", if_ins, 32'd0);
    chk("t2_fc1", fetch_cnt, PERF ? 32'd1 : 32'd0);

    // 3: redirect in WAIT before the response arrives
    do_reset();
    lat = 2;
    #1;
    chk("t3_req0", {31'd0, imem_req}, 32'd1);
    cyc();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk("t3_redir_req", {31'd0, imem_req}, 32'd0);
    cyc();
    redirect = 1'b0;
    #1;
    chk("t3_drop_valid", {31'd0, if_valid}, 32'd0);
    chk("t3_drop_req", {31'd0, imem_req}, 32'd0);
    chk("t3_drop_addr", imem_addr, 32'h100);
    cyc(); #1;
    chk("t3_stale_valid", {31'd0, if_valid}, 32'd0);
    chk("t3_req", {31'd0, imem_req}, 32'd1);
    chk("t3_addr", imem_addr, 32'h100);
    cyc(); cyc(); #1;
    chk("t3_wait_valid", {31'd0, if_valid}, 32'd0);
    cyc(); #1;
    chk("t3_valid", {31'd0, if_valid}, 32'd1);
    chk("t3_ins", if_ins, 32'h451);
    chk("t3_pc", if_pc, 32'h100);
    chk("t3_npc", if_next_pc, 32'h104);
    chk("t3_sc", stall_cnt, PERF ? 32'd2 : 32'd0);

    // 4: redirect with RVALID, then redirect while decode consumes
    do_reset();
    #1;
    chk("t4_addr0", imem_addr, 32'd0);
    cyc();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    #1;
    chk("t4_req_redir", {31'd0, imem_req}, 32'd0);
    cyc();
    redirect = 1'b0;
    #1;
    chk("t4_discard", {31'd0, if_valid}, 32'd0);
    chk("t4_req", {31'd0, imem_req}, 32'd1);
    chk("t4_addr", imem_addr, 32'h200);
    cyc(); cyc();
    redirect = 1'b1;
    redirect_pc = 32'h300;
    #1;
    chk("t4_valid", {31'd0, if_valid}, 32'd1);
    chk("t4_ins", if_ins, 32'h891);
    chk("t4_pc", if_pc, 32'h200);
    chk("t4_req_flush", {31'd0, imem_req}, 32'd0);
    cyc();
    redirect = 1'b0;
    #1;
    chk("t4_flush_valid", {31'd0, if_valid}, 32'd0);
    chk("t4_flush_ins", if_ins, 32'd0);
    chk("t4_fc", fetch_cnt, 32'd0);
    chk("t4_next_req", {31'd0, imem_req}, 32'd1);
    chk("t4_next_addr", imem_addr, 32'h300);
    chk("t4_sc", stall_cnt, PERF ? 32'd1 : 32'd0);

    // 5: 8-bit PC wrap
    rst8_n = 1'b1;
    redirect8 = 1'b1;
    redirect_pc8 = 8'hFC;
    #1;
    chk("t5_req_redir", {31'd0, req8}, 32'd0);
    cyc();
    redirect8 = 1'b0;
    #1;
    chk("t5_req", {31'd0, req8}, 32'd1);
    chk("t5_addr", {24'd0, addr8}, 32'hFC);
    cyc(); cyc(); #1;
    chk("t5_valid", {31'd0, valid8}, 32'd1);
    chk("t5_ins", ins8, 32'hA5A5_00FC);
    chk("t5_pc", {24'd0, pc8}, 32'hFC);
    chk("t5_npc", {24'd0, npc8}, 32'h00);
    chk("t5_wrap_addr", {24'd0, addr8}, 32'h00);
    cyc(); cyc(); #1;
    chk("t5_ins2", ins8, 32'hA5A5_0000);
    chk("t5_pc2", {24'd0, pc8}, 32'h00);
    chk("t5_npc2", {24'd0, npc8}, 32'h04);
    chk("t5_fc", fc8, PERF ? 32'd1 : 32'd0);
    chk("t5_sc", sc8, PERF ? 32'd1 : 32'd0);

    // 6: reset dropped mid-WAIT
    do_reset();
    #1;
    chk("t6_addr0", imem_addr, 32'd0);
    cyc(); cyc();
    lat = 3;
    #1;
    chk("t6_ins", if_ins, 32'h11);
    chk("t6_addr1", imem_addr, 32'd4);
    cyc(); cyc(); cyc(); #1;
    chk("t6_sc", stall_cnt, PERF ? 32'd2 : 32'd0);
    chk("t6_fc", fetch_cnt, PERF ? 32'd1 : 32'd0);
    chk("t6_npc_pre", if_next_pc, 32'd4);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
    chk("t6_rst_valid", {31'd0, if_valid}, 32'd0);
    chk("t6_rst_ins", if_ins, 32'd0);
    chk("t6_rst_npc", if_next_pc, 32'd0);
    chk("t6_rst_addr", imem_addr, 32'd0);
    chk("t6_rst_sc", stall_cnt, 32'd0);
    chk("t6_rst_fc", fetch_cnt, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    chk("t6_rel_req", {31'd0, imem_req}, 32'd1);
    chk("t6_rel_addr", imem_addr, 32'd0);
    cyc(); cyc(); cyc(); cyc();
    chk("t6_rel_valid", {31'd0, if_valid}, 32'd1);
    chk("t6_rel_ins", if_ins, 32'h11);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
